// File: rtl/retire_map_release_if.sv
// Retire, free-list release and AMT walk bundle for retire_map_release.
// The retire side and recoverFlag_i come from the ROB; everything else is produced by the block.
interface retire_map_release_if #(
    parameter int unsigned SIZE_LOGICAL_LOG  = 5,
    parameter int unsigned SIZE_PHYSICAL_LOG = 7
);
    logic                          retireValid0_i, retireValid1_i, retireValid2_i, retireValid3_i;
    logic                          retireHasDest0_i, retireHasDest1_i;
    logic                          retireHasDest2_i, retireHasDest3_i;
    logic [SIZE_LOGICAL_LOG-1:0]   retireLogDest0_i, retireLogDest1_i;
    logic [SIZE_LOGICAL_LOG-1:0]   retireLogDest2_i, retireLogDest3_i;
    logic [SIZE_PHYSICAL_LOG-1:0]  retirePhyDest0_i, retirePhyDest1_i;
    logic [SIZE_PHYSICAL_LOG-1:0]  retirePhyDest2_i, retirePhyDest3_i;
    logic                          recoverFlag_i;
    logic                          commitValid0_o, commitValid1_o, commitValid2_o, commitValid3_o;
    logic [SIZE_PHYSICAL_LOG-1:0]  commitReg0_o, commitReg1_o, commitReg2_o, commitReg3_o;
    logic                          walkValid_o;
    logic [SIZE_LOGICAL_LOG-3:0]   walkGroup_o;
    logic [SIZE_PHYSICAL_LOG-1:0]  walkPhy0_o, walkPhy1_o, walkPhy2_o, walkPhy3_o;
    logic                          walkBusy_o;
    logic                          recoverDone_o;

    modport master (
        output retireValid0_i, retireValid1_i, retireValid2_i, retireValid3_i,
        output retireHasDest0_i, retireHasDest1_i, retireHasDest2_i, retireHasDest3_i,
        output retireLogDest0_i, retireLogDest1_i, retireLogDest2_i, retireLogDest3_i,
        output retirePhyDest0_i, retirePhyDest1_i, retirePhyDest2_i, retirePhyDest3_i,
        output recoverFlag_i,
        input  commitValid0_o, commitValid1_o, commitValid2_o, commitValid3_o,
        input  commitReg0_o, commitReg1_o, commitReg2_o, commitReg3_o,
        input  walkValid_o, walkGroup_o, walkPhy0_o, walkPhy1_o, walkPhy2_o, walkPhy3_o,
        input  walkBusy_o, recoverDone_o
    );

    modport slave (
        input  retireValid0_i, retireValid1_i, retireValid2_i, retireValid3_i,
        input  retireHasDest0_i, retireHasDest1_i, retireHasDest2_i, retireHasDest3_i,
        input  retireLogDest0_i, retireLogDest1_i, retireLogDest2_i, retireLogDest3_i,
        input  retirePhyDest0_i, retirePhyDest1_i, retirePhyDest2_i, retirePhyDest3_i,
        input  recoverFlag_i,
        output commitValid0_o, commitValid1_o, commitValid2_o, commitValid3_o,
        output commitReg0_o, commitReg1_o, commitReg2_o, commitReg3_o,
        output walkValid_o, walkGroup_o, walkPhy0_o, walkPhy1_o, walkPhy2_o, walkPhy3_o,
        output walkBusy_o, recoverDone_o
    );
endinterface

// File: rtl/retire_map_release.sv
// Architectural map table: commits retiring destinations, releases the superseded physical
// registers to the free list and streams the table to rename on a full recovery.
module retire_map_release #(
    parameter int unsigned COMMIT_WIDTH      = 4,
    parameter int unsigned SIZE_LOGICAL      = 32,
    parameter int unsigned SIZE_LOGICAL_LOG  = 5,
    parameter int unsigned SIZE_PHYSICAL_LOG = 7
) (
    input logic                 clk,
    input logic                 reset,
    retire_map_release_if.slave bus
);
    localparam int unsigned GW = SIZE_LOGICAL_LOG - 2;
    localparam logic [GW-1:0] LastGroup = GW'(SIZE_LOGICAL / 4 - 1);

    typedef logic [SIZE_PHYSICAL_LOG-1:0] phy_t;
    typedef logic [SIZE_LOGICAL_LOG-1:0]  log_t;
    typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

    phy_t                    amt [SIZE_LOGICAL];
    logic [COMMIT_WIDTH-1:0] active;
    log_t                    logDest [COMMIT_WIDTH];
    phy_t                    phyDest [COMMIT_WIDTH];
    phy_t                    oldPhy [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] commitValidQ;
    phy_t                    commitRegQ [COMMIT_WIDTH];
    phy_t                    walkPhy [4];
    state_e                  stateQ, stateD;
    logic [GW-1:0]           groupQ, groupD;

    always_comb begin
        active[0]  = bus.retireValid0_i & bus.retireHasDest0_i;
        active[1]  = bus.retireValid1_i & bus.retireHasDest1_i;
        active[2]  = bus.retireValid2_i & bus.retireHasDest2_i;
        active[3]  = bus.retireValid3_i & bus.retireHasDest3_i;
        logDest[0] = bus.retireLogDest0_i;
        logDest[1] = bus.retireLogDest1_i;
        logDest[2] = bus.retireLogDest2_i;
        logDest[3] = bus.retireLogDest3_i;
        phyDest[0] = bus.retirePhyDest0_i;
        phyDest[1] = bus.retirePhyDest1_i;
        phyDest[2] = bus.retirePhyDest2_i;
        phyDest[3] = bus.retirePhyDest3_i;
    end

    // An older slot in the same group writing the same entry supersedes the table value;
    // ascending scan leaves the youngest such slot.
    always_comb begin
        for (int n = 0; n < COMMIT_WIDTH; n++) begin
            oldPhy[n] = amt[logDest[n]];
            for (int m = 0; m < n; m++) begin
                if (active[m] && (logDest[m] == logDest[n])) oldPhy[n] = phyDest[m];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SIZE_LOGICAL; i++) amt[i] <= phy_t'(i);
            commitValidQ <= '0;
            for (int n = 0; n < COMMIT_WIDTH; n++) commitRegQ[n] <= '0;
        end else begin
            // Later assignments win, so the highest active slot owns a shared entry.
            for (int n = 0; n < COMMIT_WIDTH; n++) begin
                if (active[n]) amt[logDest[n]] <= phyDest[n];
            end
            commitValidQ <= active;
            for (int n = 0; n < COMMIT_WIDTH; n++) begin
                commitRegQ[n] <= active[n] ? oldPhy[n] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
            groupQ <= '0;
        end else begin
            stateQ <= stateD;
            groupQ <= groupD;
        end
    end

    always_comb begin
        stateD = stateQ;
        groupD = groupQ;
        unique case (stateQ)
            StIdle: begin
                if (bus.recoverFlag_i) begin
                    stateD = StWalk;
                    groupD = '0;
                end
            end
            StWalk: begin
                if (bus.recoverFlag_i)       groupD = '0;
                else if (groupQ == LastGroup) stateD = StDone;
                else                          groupD = groupQ + GW'(1);
            end
            StDone: begin
                groupD = '0;
                stateD = bus.recoverFlag_i ? StWalk : StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            walkPhy[k] = (stateQ == StWalk) ? amt[{groupQ, 2'(k)}] : '0;
        end
    end

    assign bus.commitValid0_o = commitValidQ[0];
    assign bus.commitValid1_o = commitValidQ[1];
    assign bus.commitValid2_o = commitValidQ[2];
    assign bus.commitValid3_o = commitValidQ[3];
    assign bus.commitReg0_o   = commitRegQ[0];
    assign bus.commitReg1_o   = commitRegQ[1];
    assign bus.commitReg2_o   = commitRegQ[2];
    assign bus.commitReg3_o   = commitRegQ[3];
    assign bus.walkValid_o    = (stateQ == StWalk);
    assign bus.walkGroup_o    = (stateQ == StWalk) ? groupQ : '0;
    assign bus.walkPhy0_o     = walkPhy[0];
    assign bus.walkPhy1_o     = walkPhy[1];
    assign bus.walkPhy2_o     = walkPhy[2];
    assign bus.walkPhy3_o     = walkPhy[3];
    assign bus.walkBusy_o     = (stateQ == StWalk) || (stateQ == StDone);
    assign bus.recoverDone_o  = (stateQ == StDone);
endmodule

// File: tb/tb_retire_map_release.sv
// Bench for retire_map_release: table of retire vectors with a release scoreboard,
// plus hand-written recovery walk, restart and reset-during-walk sequences.
module tb_retire_map_release;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    retire_map_release_if #(.SIZE_LOGICAL_LOG(5), .SIZE_PHYSICAL_LOG(7)) bus ();

    retire_map_release #(
        .COMMIT_WIDTH(4), .SIZE_LOGICAL(32), .SIZE_LOGICAL_LOG(5), .SIZE_PHYSICAL_LOG(7)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [3:0]      valid;
        logic [3:0]      hasDest;
        logic [3:0][4:0] ld;
        logic [3:0][6:0] ph;
        logic [3:0]      expValid;
        logic [3:0][6:0] expReg;
    } vec_t;

    typedef struct packed {
        logic [3:0]      v;
        logic [3:0][6:0] r;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   mdl [32];
    exp_t sb [$];
    vec_t tbl [8];

    wire anyActive = (bus.retireValid0_i & bus.retireHasDest0_i) |
                     (bus.retireValid1_i & bus.retireHasDest1_i) |
                     (bus.retireValid2_i & bus.retireHasDest2_i) |
                     (bus.retireValid3_i & bus.retireHasDest3_i);

    always @(posedge clk) begin
        if (!reset) assert (!(bus.walkValid_o && anyActive))
            else $error("protocol violation: retirement during walk");
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] h,
                                input int l0, input int p0, input int l1, input int p1,
                                input int l2, input int p2, input int l3, input int p3,
                                input logic [3:0] ev, input int e0, input int e1,
                                input int e2, input int e3);
        vec_t r;
        r.valid = v;        r.hasDest = h;
        r.ld[0] = 5'(l0);   r.ph[0] = 7'(p0);
        r.ld[1] = 5'(l1);   r.ph[1] = 7'(p1);
        r.ld[2] = 5'(l2);   r.ph[2] = 7'(p2);
        r.ld[3] = 5'(l3);   r.ph[3] = 7'(p3);
        r.expValid = ev;
        r.expReg[0] = 7'(e0); r.expReg[1] = 7'(e1);
        r.expReg[2] = 7'(e2); r.expReg[3] = 7'(e3);
        return r;
    endfunction

    task automatic setSlot(input int n, input logic v, input logic h, input int ld, input int ph);
        case (n)
            0: begin bus.retireValid0_i = v; bus.retireHasDest0_i = h;
                     bus.retireLogDest0_i = 5'(ld); bus.retirePhyDest0_i = 7'(ph); end
            1: begin bus.retireValid1_i = v; bus.retireHasDest1_i = h;
                     bus.retireLogDest1_i = 5'(ld); bus.retirePhyDest1_i = 7'(ph); end
            2: begin bus.retireValid2_i = v; bus.retireHasDest2_i = h;
                     bus.retireLogDest2_i = 5'(ld); bus.retirePhyDest2_i = 7'(ph); end
            default: begin bus.retireValid3_i = v; bus.retireHasDest3_i = h;
                     bus.retireLogDest3_i = 5'(ld); bus.retirePhyDest3_i = 7'(ph); end
        endcase
    endtask

    task automatic clearInputs();
        for (int n = 0; n < 4; n++) setSlot(n, 1'b0, 1'b0, 0, 0);
        bus.recoverFlag_i = 1'b0;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 32; i++) mdl[i] = i;
    endtask

    function automatic int commitValidVec();
        return {28'd0, bus.commitValid3_o, bus.commitValid2_o, bus.commitValid1_o,
                bus.commitValid0_o};
    endfunction

    function automatic int commitReg(input int n);
        case (n)
            0: return int'(bus.commitReg0_o);
            1: return int'(bus.commitReg1_o);
            2: return int'(bus.commitReg2_o);
            default: return int'(bus.commitReg3_o);
        endcase
    endfunction

    function automatic int walkPhy(input int k);
        case (k)
            0: return int'(bus.walkPhy0_o);
            1: return int'(bus.walkPhy1_o);
            2: return int'(bus.walkPhy2_o);
            default: return int'(bus.walkPhy3_o);
        endcase
    endfunction

    // Drives one retire group, updates the bench AMT model and queues the expected release.
    task automatic driveVec(input vec_t v);
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            setSlot(n, v.valid[n], v.hasDest[n], int'(v.ld[n]), int'(v.ph[n]));
            if (v.valid[n] && v.hasDest[n]) mdl[v.ld[n]] = int'(v.ph[n]);
        end
        e.v = v.expValid;
        e.r = v.expReg;
        sb.push_back(e);
    endtask

    task automatic checkCommit(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, " scoreboard empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({name, " commitValid"}, commitValidVec(), int'(e.v));
        for (int n = 0; n < 4; n++) chk($sformatf("%s commitReg%0d", name, n), commitReg(n),
                                        int'(e.r[n]));
    endtask

    task automatic checkGroup(input string name, input int g);
        chk({name, " walkValid"}, int'(bus.walkValid_o), 1);
        chk({name, " walkBusy"}, int'(bus.walkBusy_o), 1);
        chk({name, " walkGroup"}, int'(bus.walkGroup_o), g);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s g%0d walkPhy%0d", name, g, k), walkPhy(k), mdl[4 * g + k]);
    endtask

    task automatic checkIdle(input string name);
        chk({name, " walkBusy"}, int'(bus.walkBusy_o), 0);
        chk({name, " walkValid"}, int'(bus.walkValid_o), 0);
        chk({name, " recoverDone"}, int'(bus.recoverDone_o), 0);
    endtask

    // Full walk from an idle start; ends one cycle after DONE.
    task automatic runWalk(input string name);
        bus.recoverFlag_i = 1'b1;
        tick();
        bus.recoverFlag_i = 1'b0;
        for (int g = 0; g < 8; g++) begin
            checkGroup(name, g);
            tick();
        end
        chk({name, " recoverDone"}, int'(bus.recoverDone_o), 1);
        chk({name, " done busy"}, int'(bus.walkBusy_o), 1);
        chk({name, " done walkValid"}, int'(bus.walkValid_o), 0);
        tick();
        checkIdle({name, " after"});
    endtask

    initial begin
        tbl[0] = mk(4'b0001, 4'b0001, 5, 40, 0, 0, 0, 0, 0, 0, 4'b0001, 5, 0, 0, 0);
        tbl[1] = mk(4'b0001, 4'b0001, 5, 41, 0, 0, 0, 0, 0, 0, 4'b0001, 40, 0, 0, 0);
        tbl[2] = mk(4'b1111, 4'b1111, 3, 50, 3, 51, 3, 52, 3, 53, 4'b1111, 3, 50, 51, 52);
        tbl[3] = mk(4'b0001, 4'b0001, 3, 55, 0, 0, 0, 0, 0, 0, 4'b0001, 53, 0, 0, 0);
        tbl[4] = mk(4'b1010, 4'b1010, 0, 0, 7, 60, 0, 0, 9, 61, 4'b1010, 0, 7, 0, 9);
        tbl[5] = mk(4'b0101, 4'b0001, 10, 80, 0, 0, 5, 99, 0, 0, 4'b0001, 10, 0, 0, 0);
        tbl[6] = mk(4'b0101, 4'b0101, 5, 90, 0, 0, 5, 91, 0, 0, 4'b0101, 41, 0, 90, 0);
        tbl[7] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);

        clearInputs();
        resetModel();
        reset = 1'b1;
        repeat (3) tick();
        chk("reset commitValid", commitValidVec(), 0);
        for (int n = 0; n < 4; n++) chk($sformatf("reset commitReg%0d", n), commitReg(n), 0);
        chk("reset walkGroup", int'(bus.walkGroup_o), 0);
        for (int k = 0; k < 4; k++) chk($sformatf("reset walkPhy%0d", k), walkPhy(k), 0);
        checkIdle("reset");
        reset = 1'b0;
        repeat (3) tick();
        chk("idle commitValid", commitValidVec(), 0);
        checkIdle("idle");

        runWalk("identity walk");

        for (int i = 0; i <= 8; i++) begin
            if (sb.size() != 0) checkCommit($sformatf("vec%0d", i - 1));
            if (i < 8) driveVec(tbl[i]);
            else clearInputs();
            tick();
        end
        chk("scoreboard drained", sb.size(), 0);
        runWalk("post-retire walk");

        // Recovery with a same-cycle retire, then a restart at group 4.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        resetModel();
        driveVec(mk(4'b0001, 4'b0001, 2, 70, 0, 0, 0, 0, 0, 0, 4'b0001, 2, 0, 0, 0));
        bus.recoverFlag_i = 1'b1;
        tick();
        clearInputs();
        checkCommit("recover retire");
        chk("recover g0 phy0", walkPhy(0), 0);
        chk("recover g0 phy1", walkPhy(1), 1);
        chk("recover g0 phy2", walkPhy(2), 70);
        chk("recover g0 phy3", walkPhy(3), 3);
        checkGroup("recover", 0);
        tick();
        for (int g = 1; g <= 4; g++) begin
            checkGroup("recover", g);
            if (g == 4) bus.recoverFlag_i = 1'b1;
            tick();
        end
        bus.recoverFlag_i = 1'b0;
        for (int g = 0; g < 8; g++) begin
            checkGroup("restart", g);
            tick();
        end
        chk("restart recoverDone", int'(bus.recoverDone_o), 1);
        tick();
        checkIdle("restart after");

        // Reset in the middle of a walk must abort it and restore the identity map.
        driveVec(mk(4'b0010, 4'b0010, 0, 0, 6, 100, 0, 0, 0, 0, 4'b0010, 0, 6, 0, 0));
        tick();
        clearInputs();
        checkCommit("pre-abort retire");
        bus.recoverFlag_i = 1'b1;
        tick();
        bus.recoverFlag_i = 1'b0;
        for (int g = 0; g < 5; g++) tick();
        chk("abort at group", int'(bus.walkGroup_o), 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        resetModel();
        checkIdle("abort");
        chk("abort commitValid", commitValidVec(), 0);
        runWalk("post-abort walk");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/retire_map_release.md
Name: retire_map_release

Overview:
- Commit-side partner of the speculative free list.
- Holds the Architectural Map Table (AMT): logical register to committed physical register.
- Up to 4 instructions retire per cycle; for each retiring instruction with a destination, the block updates the AMT entry and releases the previously committed physical register.
- Released registers go out on the free list push interface (commitValidN/commitRegN).
- On a full pipeline recovery, it streams the AMT contents to the rename map table, 4 entries per cycle.

Parameters:
- COMMIT_WIDTH, 4, retire slots per cycle. Fixed at 4; the ports are unrolled.
- SIZE_LOGICAL, 32, number of logical registers. Must be a multiple of 4.
- SIZE_LOGICAL_LOG, 5, log2(SIZE_LOGICAL).
- SIZE_PHYSICAL_LOG, 7, physical register tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- retireValidN_i (N=0..3)  in  1  slot N retires this cycle
- retireHasDestN_i  in  1  slot N writes a destination register
- retireLogDestN_i  in  SIZE_LOGICAL_LOG  logical destination of slot N
- retirePhyDestN_i  in  SIZE_PHYSICAL_LOG  physical register newly committed by slot N
- recoverFlag_i  in  1  single-cycle pulse that starts the AMT walk
- commitValidN_o  out  1  push request to the free list, slot N
- commitRegN_o  out  SIZE_PHYSICAL_LOG  physical register released, slot N
- walkValid_o  out  1  walk data valid this cycle
- walkGroup_o  out  SIZE_LOGICAL_LOG-2  group index; entries 4*g .. 4*g+3
- walkPhyK_o (K=0..3)  out  SIZE_PHYSICAL_LOG  AMT[4*walkGroup_o+K]
- walkBusy_o  out  1  walk in progress
- recoverDone_o  out  1  one-cycle pulse after the last group

Behaviour:
- Reset:
  - AMT[i] = i for every i.
  - All outputs 0.
  - FSM = IDLE.
  - Reset overrides every other input, including a walk in progress.
- Slot N is active when retireValidN_i & retireHasDestN_i.
- Release, for an active slot N:
  - old_N = the AMT entry for retireLogDestN_i, as seen by slot N.
  - If an earlier active slot M<N in the same cycle has the same logical destination, old_N = retirePhyDestM_i of the highest such M. Otherwise old_N = AMT[retireLogDestN_i] registered value.
- AMT write:
  - AMT[retireLogDestN_i] <= retirePhyDestN_i at the next clk edge.
  - When several slots target the same entry, the highest active slot wins.
- Release outputs are registered, 1-cycle latency:
  - commitValidN_o <= active_N; commitRegN_o <= old_N.
  - Lanes are positional, not compacted. The free list accepts sparse patterns.
  - When commitValidN_o = 0, commitRegN_o = 0.
- Inactive slots leave the AMT unchanged. retirePhyDestN_i is ignored.
- Exactly one release per active slot. No register is ever dropped or duplicated.
- FSM, IDLE -> WALK -> DONE -> IDLE:
  - IDLE: recoverFlag_i -> WALK, group counter g = 0.
  - WALK: each cycle walkValid_o=1, walkGroup_o=g, walkPhyK_o = AMT[4g+K]. These outputs are combinational reads of the registered AMT plus the registered g. g increments each cycle. At g = SIZE_LOGICAL/4-1 -> DONE.
  - DONE: recoverDone_o=1 for 1 cycle -> IDLE.
  - walkBusy_o = 1 in WALK and DONE.
- Walk length: SIZE_LOGICAL/4 cycles of data plus 1 DONE cycle; 9 cycles at the defaults.
- Retirement in the same cycle as recoverFlag_i is applied to the AMT. The walk's first read, on the next cycle, sees the update.
- recoverFlag_i while in WALK or DONE restarts the walk at g=0.
- Retirement during WALK is a protocol violation; the upstream ROB is flushed. If it occurs anyway:
  - The AMT update and releases are still performed.
  - Groups already emitted may be stale.
  - The bench flags it with an assertion.
- The release path is independent of the FSM. Releases issued in the cycle before recovery still appear on commit*_o.

Test Plan:
- Reset, then idle 3 cycles -> commitValid*_o=0, walkBusy_o=0. A walk then shows walkPhyK_o = 4g+K for every g.
- Slot0 retires logDest=5, phy=40 -> next cycle commitValid0_o=1, commitReg0_o=5, other lanes 0. A subsequent retire of logDest=5, phy=41 releases 40.
- One cycle, all 4 slots valid with logDest=3 and phys 50,51,52,53 -> releases 3,50,51,52 on lanes 0..3. AMT[3]=53.
- Sparse pattern 4'b1010: slot1 logDest=7 phy=60, slot3 logDest=9 phy=61 -> commitValid = 4'b1010, commitReg1_o=7, commitReg3_o=9.
- recoverFlag_i together with retire logDest=2 phy=70 -> 8 walk cycles, group 0 shows {0,1,70,3}, then recoverDone_o for 1 cycle. A second recoverFlag_i at group 4 restarts at group 0.
- Assert reset during WALK group 5 -> next cycle walkBusy_o=0 and the AMT is back to identity.
